data_mem_ctrl: RTL

- Controller in front of the single-port `DataMemory` byte array.
- Arbitrates between two requesters: port 0 is the core load/store unit, port 1 is the debug/program loader.
- Sequences byte, half and word accesses over the memory's word-only port, doing read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Byte order is fixed by the memory: the byte at address `a` is bits [31:24] of the word read at `a`.

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/data_mem_ctrl_if.sv | 33 +++
 rtl/DataMemory.sv | 46 ++++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/data_mem_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data memory controller.
//   mem_size_e  - access size encoding carried on req_size (2'b11 is illegal).
//   dmc_state_e - controller FSM states.
//   DEPTH       - default memory depth in bytes (SIZE * BYTE_WIDTH).
package data_mem_pkg;

    localparam int unsigned DEFAULT_SIZE       = 32;
    localparam int unsigned DEFAULT_BYTE_WIDTH = 8;
    localparam int unsigned DEPTH              = DEFAULT_SIZE * DEFAULT_BYTE_WIDTH;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StWrite  = 2'b10,
        StResp   = 2'b11
    } dmc_state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: two-port request/response bundle between requesters and the controller.
//   Index 0 is the core load/store unit, index 1 the debug/program loader.
//   req_valid/req_ready  - per-port handshake; req_ready is one-hot or zero.
//   req_write/size/unsigned/addr/wdata - request fields, held stable until ready.
//   rsp_valid            - one-cycle response pulse to the originating port.
//   rsp_err/rsp_rdata    - response payload, qualified by rsp_valid.
// Modports: master = requester side, slave = controller side.
interface data_mem_ctrl_if #(
    parameter int unsigned N = 32
);

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [1:0][1:0]     req_size;
    logic [1:0]          req_unsigned;
    logic [1:0][N-1:0]   req_addr;
    logic [1:0][N-1:0]   req_wdata;
    logic [1:0]          rsp_valid;
    logic                rsp_err;
    logic [N-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/DataMemory.sv
// DataMemory: single-port byte array with a word-wide port.
//   clk          - write clock.
//   addr         - byte address of the word; byte at addr lands in the top byte.
//   write_enable - store write_data at addr on the rising edge.
//   write_data   - word to store, most significant byte first.
//   read_data    - combinational word read at addr.
// Addresses wrap modulo DEPTH inside the array.
module DataMemory #(
    parameter int unsigned N          = 32,
    parameter int unsigned SIZE       = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic         clk,
    input  logic [N-1:0] addr,
    input  logic         write_enable,
    input  logic [N-1:0] write_data,
    output logic [N-1:0] read_data
);

    localparam int unsigned Depth = SIZE * BYTE_WIDTH;
    localparam int unsigned Aw    = $clog2(Depth);
    localparam int unsigned Bytes = N / BYTE_WIDTH;

    logic [BYTE_WIDTH-1:0] mem [Depth];
    logic [Aw-1:0]         idx;
    logic                  unused_addr;

    assign idx         = addr[Aw-1:0];
    assign unused_addr = ^addr[N-1:Aw];

    always_comb begin
        read_data = '0;
        for (int i = 0; i < Bytes; i++) begin
            read_data[N-1-i*BYTE_WIDTH -: BYTE_WIDTH] = mem[idx + Aw'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (write_enable) begin
            for (int i = 0; i < Bytes; i++) begin
                mem[idx + Aw'(i)] <= write_data[N-1-i*BYTE_WIDTH -: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst - clock and synchronous active-high reset.
//   req      - request vector.
//   advance  - a grant was consumed this cycle; updates the priority pointer.
//   grant    - combinational one-hot grant (zero when nothing requests).
// last_q holds the index of the most recently served port; it resets to 1 so
// port 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: arbitrated byte/half/word access controller for DataMemory.
//   clk, rst          - clock and synchronous active-high reset.
//   bus               - two-port request/response bundle (slave side).
//   mem_addr          - word address to the memory; 0 when idle or responding.
//   mem_write_enable  - memory write strobe (word store in ACCESS, RMW in WRITE).
//   mem_write_data    - memory write word; 0 when not writing.
//   mem_read_data     - combinational memory read word.
// Sub-word accesses use the top bytes of the word read at the byte address, so
// a byte store is read-modify-write over two cycles (ACCESS then WRITE).
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter int unsigned SIZE       = DEFAULT_SIZE,
    parameter int unsigned BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus,
    output logic [N-1:0]   mem_addr,
    output logic           mem_write_enable,
    output logic [N-1:0]   mem_write_data,
    input  logic [N-1:0]   mem_read_data
);

    localparam int unsigned MemDepth  = SIZE * BYTE_WIDTH;
    localparam int unsigned HalfWidth = 2 * BYTE_WIDTH;
    // Highest address whose full word still fits in the array.
    localparam logic [N-1:0] MaxAddr  = N'(MemDepth - 4);

    dmc_state_e state_q, state_d;

    logic          port_q;
    logic          write_q;
    mem_size_e     size_q;
    logic          uns_q;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  wdata_q;
    logic          err_q;
    logic [N-1:0]  rdata_q;
    logic [N-1:0]  merge_q;

    logic [1:0]    grant;
    logic          sel;
    logic          accept;
    logic          req_bad;
    logic          we;
    logic [1:0]    rsp_valid;

    logic [BYTE_WIDTH-1:0] rd_byte;
    logic [HalfWidth-1:0]  rd_half;
    logic [N-1:0]          load_ext;
    logic [N-1:0]          merge;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign sel     = grant[1];
    assign accept  = (state_q == StIdle) && !rst && (bus.req_valid != 2'b00);
    assign req_bad = (bus.req_size[sel] == 2'b11) || (bus.req_addr[sel] > MaxAddr);

    assign bus.req_ready = (state_q == StIdle && !rst) ? grant : 2'b00;

    // Sub-word data always sits at the top of the word read at the byte address.
    assign rd_byte = mem_read_data[N-1 -: BYTE_WIDTH];
    assign rd_half = mem_read_data[N-1 -: HalfWidth];

    always_comb begin
        load_ext = mem_read_data;
        merge    = wdata_q;
        case (size_q)
            SizeByte: begin
                load_ext = {{(N-BYTE_WIDTH){rd_byte[BYTE_WIDTH-1] & ~uns_q}}, rd_byte};
                merge    = {wdata_q[BYTE_WIDTH-1:0], mem_read_data[N-BYTE_WIDTH-1:0]};
            end
            SizeHalf: begin
                load_ext = {{(N-HalfWidth){rd_half[HalfWidth-1] & ~uns_q}}, rd_half};
                merge    = {wdata_q[HalfWidth-1:0], mem_read_data[N-HalfWidth-1:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mem_addr       = '0;
        we             = 1'b0;
        mem_write_data = '0;
        rsp_valid      = 2'b00;
        bus.rsp_err    = 1'b0;
        bus.rsp_rdata  = '0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_bad ? StResp : StAccess;
                end
            end
            StAccess: begin
                mem_addr = addr_q;
                if (!write_q) begin
                    state_d = StResp;
                end else if (size_q == SizeWord) begin
                    we             = 1'b1;
                    mem_write_data = wdata_q;
                    state_d        = StResp;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                mem_addr       = addr_q;
                we             = 1'b1;
                mem_write_data = merge_q;
                state_d        = StResp;
            end
            StResp: begin
                if (!rst) begin
                    rsp_valid[port_q] = 1'b1;
                    bus.rsp_err       = err_q;
                    bus.rsp_rdata     = rdata_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset in the same cycle drops any pending write.
    assign mem_write_enable = we & ~rst;
    assign bus.rsp_valid    = rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q  <= 1'b0;
            write_q <= 1'b0;
            size_q  <= SizeByte;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                port_q  <= sel;
                write_q <= bus.req_write[sel];
                size_q  <= mem_size_e'(bus.req_size[sel]);
                uns_q   <= bus.req_unsigned[sel];
                addr_q  <= bus.req_addr[sel];
                wdata_q <= bus.req_wdata[sel];
                err_q   <= req_bad;
                rdata_q <= '0;
            end
            if (state_q == StAccess) begin
                if (write_q) begin
                    merge_q <= merge;
                end else begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

endmodule
